// File: rtl/fpu_divide_iterative_pkg.sv
// fpu_divide_iterative_pkg: shared types, flag indices and operand class decode for the iterative divider.
package fpu_divide_iterative_pkg;
    typedef enum logic [2:0] {RM_RNE, RM_RTZ, RM_RDN, RM_RUP, RM_RMM} fpu_round_mode_t;
    typedef enum logic [1:0] {IDLE, ITERATE, NORMALIZE, DONE} fpu_div_state_t;
    typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} fpu_class_t;
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;
    // Width-agnostic: callers reduce their own exponent/mantissa fields; subnormals read as zero.
    function automatic fpu_class_t fpu_classify(input logic exp_zero, input logic exp_ones, input logic mant_zero);
        return exp_zero ? CLS_ZERO : !exp_ones ? CLS_NORM : mant_zero ? CLS_INF : CLS_NAN;
    endfunction
endpackage

// File: rtl/fpu_divide_step.sv
// fpu_divide_step: combinational chain of STEPS restoring-division stages.
module fpu_divide_step #(
    parameter int RW    = 25,
    parameter int QW    = 27,
    parameter int STEPS = 1
) (
    input  logic [RW-1:0] r_i,
    input  logic [RW-1:0] d_i,
    input  logic [QW-1:0] q_i,
    output logic [RW-1:0] r_o,
    output logic [QW-1:0] q_o
);
    always_comb begin
        r_o = r_i;
        q_o = q_i;
        for (int i = 0; i < STEPS; i++) begin
            q_o = {q_o[QW-2:0], r_o >= d_i};
            r_o = (r_o >= d_i ? r_o - d_i : r_o) << 1;
        end
    end
endmodule

// File: rtl/fpu_divide_iterative.sv
// fpu_divide_iterative: multi-cycle restoring float divider emitting unrounded mantissa, guard bits and flags.
module fpu_divide_iterative
    import fpu_divide_iterative_pkg::*;
#(
    parameter int EXP_WIDTH      = 8,
    parameter int MANT_WIDTH     = 23,
    parameter int GUARD_BITS     = 3,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [EXP_WIDTH+MANT_WIDTH:0] in_a,
    input  logic [EXP_WIDTH+MANT_WIDTH:0] in_b,
    input  fpu_round_mode_t               in_mode,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_sign,
    output logic [EXP_WIDTH-1:0]          out_exponent,
    output logic [MANT_WIDTH:0]           out_mantissa,
    output logic [GUARD_BITS-1:0]         out_guard,
    output logic                          out_nan,
    output logic                          out_inf,
    output logic                          out_zero,
    output fpu_round_mode_t               out_mode,
    output logic [4:0]                    out_flags
);
    localparam int E    = EXP_WIDTH;
    localparam int M    = MANT_WIDTH;
    localparam int G    = GUARD_BITS;
    localparam int Q    = M + 1 + G;
    localparam int N    = (Q + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
    localparam int QX   = N * BITS_PER_CYCLE;
    localparam int CW   = $clog2(N + 1);
    localparam int BIAS = 2 ** (E - 1) - 1;

    fpu_div_state_t  state_q, state_d;
    fpu_class_t      ca, cb, cls_d, cls_q;
    fpu_round_mode_t mode_q, out_mode_q;
    logic            accept, dz_d, dz_q, sign_q;
    logic [CW-1:0]   cnt_q;
    logic [M+1:0]    r_q, d_q, r_step;
    logic [QX-1:0]   q_q, q_step;
    logic [E+1:0]    exp_q, exp_n;
    logic [QX:0]     qx;
    logic [Q-1:0]    qt, qn;
    logic [G-1:0]    gd;
    logic            shift, stk, spec, ovf, unf, norm;
    logic [4:0]      flags_n, out_flags_q;
    logic            out_sign_q, out_nan_q, out_inf_q, out_zero_q;
    logic [E-1:0]    out_exp_q;
    logic [M:0]      out_mant_q;
    logic [G-1:0]    out_guard_q;

    assign ca = fpu_classify(in_a[E+M-1:M] == '0, &in_a[E+M-1:M], in_a[M-1:0] == '0);
    assign cb = fpu_classify(in_b[E+M-1:M] == '0, &in_b[E+M-1:M], in_b[M-1:0] == '0);
    // Ternary order encodes special-case priority: nan, then x/0 and inf/x, then zero results.
    assign cls_d = (ca == CLS_NAN || cb == CLS_NAN || (ca == CLS_ZERO && cb == CLS_ZERO) ||
                    (ca == CLS_INF && cb == CLS_INF)) ? CLS_NAN
                 : (ca == CLS_INF || cb == CLS_ZERO) ? CLS_INF
                 : (ca == CLS_ZERO || cb == CLS_INF) ? CLS_ZERO : CLS_NORM;
    assign dz_d   = ca == CLS_NORM && cb == CLS_ZERO;
    assign accept = state_q == IDLE && in_valid;

    fpu_divide_step #(.RW(M + 2), .QW(QX), .STEPS(BITS_PER_CYCLE)) u_step (
        .r_i(r_q),
        .d_i(d_q),
        .q_i(q_q),
        .r_o(r_step),
        .q_o(q_step)
    );

    // Quotient bits past the first Q land in the low slice of qx and fold into sticky.
    assign qx    = {q_q, 1'b0};
    assign qt    = qx[QX -: Q];
    assign shift = !qt[Q-1];
    assign qn    = shift ? qt << 1 : qt;
    assign exp_n = exp_q - (E + 2)'(shift);
    assign stk   = |qx[QX-Q:0] || r_q != '0;
    assign gd    = qn[G-1:0] | G'(stk);
    assign spec  = cls_q != CLS_NORM;
    assign ovf   = !spec && !exp_n[E+1] && exp_n[E:0] >= (E + 1)'(2 ** E - 1);
    assign unf   = !spec && (exp_n[E+1] || exp_n == '0);
    assign norm  = !spec && !ovf && !unf;

    always_comb begin
        flags_n          = '0;
        flags_n[FLAG_NV] = cls_q == CLS_NAN;
        flags_n[FLAG_DZ] = dz_q;
        flags_n[FLAG_OF] = ovf;
        flags_n[FLAG_UF] = unf;
        flags_n[FLAG_NX] = ovf || unf || (norm && |gd);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE      ? (in_valid ? (cls_d != CLS_NORM ? NORMALIZE : ITERATE) : IDLE)
                : state_q == ITERATE   ? (cnt_q == CW'(N - 1) ? NORMALIZE : ITERATE)
                : state_q == NORMALIZE ? DONE
                : out_ready            ? IDLE : DONE;
    end

    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = state_q == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            r_q         <= '0;
            d_q         <= '0;
            q_q         <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            dz_q        <= 1'b0;
            cls_q       <= CLS_ZERO;
            mode_q      <= RM_RNE;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_mant_q  <= '0;
            out_guard_q <= '0;
            out_nan_q   <= 1'b0;
            out_inf_q   <= 1'b0;
            out_zero_q  <= 1'b0;
            out_mode_q  <= RM_RNE;
            out_flags_q <= '0;
        end else begin
            if (accept) begin
                sign_q <= in_a[E+M] ^ in_b[E+M];
                exp_q  <= {2'b00, in_a[E+M-1:M]} - {2'b00, in_b[E+M-1:M]} + (E + 2)'(BIAS);
                r_q    <= {2'b01, in_a[M-1:0]};
                d_q    <= {2'b01, in_b[M-1:0]};
                q_q    <= '0;
                cnt_q  <= '0;
                cls_q  <= cls_d;
                dz_q   <= dz_d;
                mode_q <= in_mode;
            end
            if (state_q == ITERATE) begin
                r_q   <= r_step;
                q_q   <= q_step;
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == NORMALIZE) begin
                out_sign_q  <= sign_q;
                out_exp_q   <= (cls_q == CLS_NAN || cls_q == CLS_INF || ovf) ? '1 : norm ? exp_n[E-1:0] : '0;
                out_mant_q  <= norm ? qn[Q-1:G] : '0;
                out_guard_q <= norm ? gd : '0;
                out_nan_q   <= cls_q == CLS_NAN;
                out_inf_q   <= cls_q == CLS_INF || ovf;
                out_zero_q  <= cls_q == CLS_ZERO || unf;
                out_mode_q  <= mode_q;
                out_flags_q <= flags_n;
            end
        end
    end

    assign out_sign     = out_sign_q;
    assign out_exponent = out_exp_q;
    assign out_mantissa = out_mant_q;
    assign out_guard    = out_guard_q;
    assign out_nan      = out_nan_q;
    assign out_inf      = out_inf_q;
    assign out_zero     = out_zero_q;
    assign out_mode     = out_mode_q;
    assign out_flags    = out_flags_q;
endmodule

// File: tb/tb_fpu_divide_iterative.sv
// tb_fpu_divide_iterative: scoreboard bench driving one- and three-bit-per-cycle dividers in lockstep.
module tb_fpu_divide_iterative;
    import fpu_divide_iterative_pkg::*;

    typedef struct {
        logic            sg;
        logic [7:0]      ex;
        logic [23:0]     mt;
        logic [2:0]      gd;
        logic [2:0]      cls;
        logic [4:0]      fl;
        fpu_round_mode_t md;
        int              lat;
        int              t;
    } exp_t;

    logic            clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic [31:0]     in_a = '0, in_b = '0;
    fpu_round_mode_t in_mode = RM_RNE;

    logic            rdy1, ov1, sg1, nan1, inf1, zr1, rdy3, ov3, sg3, nan3, inf3, zr3;
    logic [7:0]      ex1, ex3;
    logic [23:0]     mt1, mt3;
    logic [2:0]      gd1, gd3;
    logic [4:0]      fl1, fl3;
    fpu_round_mode_t md1, md3;

    exp_t sb1[$], sb3[$];
    exp_t e1, e3;
    int   cyc = 0, n_vec = 0, n_err = 0;
    logic pv1 = 1'b0, pv3 = 1'b0;

    fpu_divide_iterative #(.BITS_PER_CYCLE(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_a(in_a), .in_b(in_b),
        .in_mode(in_mode), .out_valid(ov1), .out_ready(out_ready), .out_sign(sg1),
        .out_exponent(ex1), .out_mantissa(mt1), .out_guard(gd1), .out_nan(nan1),
        .out_inf(inf1), .out_zero(zr1), .out_mode(md1), .out_flags(fl1)
    );

    fpu_divide_iterative #(.BITS_PER_CYCLE(3)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3), .in_a(in_a), .in_b(in_b),
        .in_mode(in_mode), .out_valid(ov3), .out_ready(out_ready), .out_sign(sg3),
        .out_exponent(ex3), .out_mantissa(mt3), .out_guard(gd3), .out_nan(nan3),
        .out_inf(inf3), .out_zero(zr3), .out_mode(md3), .out_flags(fl3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic cmp(input string t, input exp_t e, input logic sg, input logic [7:0] ex,
                       input logic [23:0] mt, input logic [2:0] gd, input logic [2:0] cls,
                       input logic [4:0] fl, input fpu_round_mode_t md);
        chk({t, ".latency"}, 64'(cyc - e.t + 1), 64'(e.lat));
        chk({t, ".sign"}, 64'(sg), 64'(e.sg));
        chk({t, ".exponent"}, 64'(ex), 64'(e.ex));
        chk({t, ".mantissa"}, 64'(mt), 64'(e.mt));
        chk({t, ".guard"}, 64'(gd), 64'(e.gd));
        chk({t, ".class"}, 64'(cls), 64'(e.cls));
        chk({t, ".flags"}, 64'(fl), 64'(e.fl));
        chk({t, ".mode"}, 64'(md), 64'(e.md));
    endtask

    // Monitor: each rising out_valid consumes one scoreboard entry.
    always @(negedge clk) begin
        if (ov1 && !pv1) begin
            if (sb1.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL bpc1.unexpected: got out_valid=1, required 0");
            end else begin
                e1 = sb1.pop_front();
                cmp("bpc1", e1, sg1, ex1, mt1, gd1, {nan1, inf1, zr1}, fl1, md1);
            end
        end
        if (ov3 && !pv3) begin
            if (sb3.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL bpc3.unexpected: got out_valid=1, required 0");
            end else begin
                e3 = sb3.pop_front();
                cmp("bpc3", e3, sg3, ex3, mt3, gd3, {nan3, inf3, zr3}, fl3, md3);
            end
        end
        pv1 = ov1;
        pv3 = ov3;
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input fpu_round_mode_t md,
                         input logic push, input logic spec, input logic sg, input logic [7:0] ex,
                         input logic [23:0] mt, input logic [2:0] gd, input logic [2:0] cls,
                         input logic [4:0] fl);
        exp_t e;
        int   k;
        k = 0;
        while (!(rdy1 && rdy3) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k == 200) begin
            n_vec++; n_err++;
            $display("FAIL issue.in_ready: got %b/%b, required 1/1", rdy1, rdy3);
        end
        in_a = a; in_b = b; in_mode = md; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        e = '{sg, ex, mt, gd, cls, fl, md, spec ? 2 : 29, cyc};
        if (push) begin
            sb1.push_back(e);
            e.lat = spec ? 2 : 11;
            sb3.push_back(e);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb1.size() != 0 || sb3.size() != 0 || !rdy1 || !rdy3) && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k == 500) begin
            n_vec++; n_err++;
            $display("FAIL drain.timeout: got %0d/%0d pending, required 0/0", sb1.size(), sb3.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish within 20000 cycles");
        $fatal(1);
    end

    initial begin
        int k;
        repeat (3) @(negedge clk);
        chk("reset.in_ready1", 64'(rdy1), 64'(1));
        chk("reset.out_valid1", 64'(ov1), 64'(0));
        chk("reset.flags1", 64'(fl1), 64'(0));
        chk("reset.exponent1", 64'(ex1), 64'(0));
        chk("reset.mantissa1", 64'(mt1), 64'(0));
        chk("reset.in_ready3", 64'(rdy3), 64'(1));
        chk("reset.out_valid3", 64'(ov3), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        issue(32'h40C00000, 32'h40000000, RM_RNE, 1, 0, 0, 8'h80, 24'hC00000, 3'b000, 3'b000, 5'b00000);
        issue(32'h3F800000, 32'h40400000, RM_RTZ, 1, 0, 0, 8'h7D, 24'hAAAAAA, 3'b101, 3'b000, 5'b00001);
        issue(32'hC0C00000, 32'h40000000, RM_RUP, 1, 0, 1, 8'h80, 24'hC00000, 3'b000, 3'b000, 5'b00000);
        issue(32'h3F800000, 32'h00000000, RM_RNE, 1, 1, 0, 8'hFF, 24'h000000, 3'b000, 3'b010, 5'b01000);
        issue(32'h00000000, 32'h00000000, RM_RDN, 1, 1, 0, 8'hFF, 24'h000000, 3'b000, 3'b100, 5'b10000);
        issue(32'h7F800000, 32'h7F800000, RM_RMM, 1, 1, 0, 8'hFF, 24'h000000, 3'b000, 3'b100, 5'b10000);
        issue(32'h40000000, 32'h7F800000, RM_RNE, 1, 1, 0, 8'h00, 24'h000000, 3'b000, 3'b001, 5'b00000);
        issue(32'h7FC00000, 32'h3F800000, RM_RNE, 1, 1, 0, 8'hFF, 24'h000000, 3'b000, 3'b100, 5'b10000);
        issue(32'h7F000000, 32'h00800000, RM_RNE, 1, 0, 0, 8'hFF, 24'h000000, 3'b000, 3'b010, 5'b00101);
        issue(32'h00800000, 32'h7F000000, RM_RNE, 1, 0, 0, 8'h00, 24'h000000, 3'b000, 3'b001, 5'b00011);
        drain();
        out_ready = 1'b0;
        issue(32'h40C00000, 32'h40000000, RM_RNE, 1, 0, 0, 8'h80, 24'hC00000, 3'b000, 3'b000, 5'b00000);
        k = 0;
        while (!ov1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        repeat (10) begin
            @(negedge clk);
            chk("hold.out_valid", 64'(ov1), 64'(1));
            chk("hold.in_ready", 64'(rdy1), 64'(0));
            chk("hold.mantissa", 64'(mt1), 64'(24'hC00000));
            chk("hold.exponent", 64'(ex1), 64'(8'h80));
        end
        out_ready = 1'b1;
        drain();
        issue(32'h40C00000, 32'h40000000, RM_RNE, 0, 0, 0, 8'h80, 24'hC00000, 3'b000, 3'b000, 5'b00000);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.in_ready1", 64'(rdy1), 64'(1));
        chk("abort.out_valid1", 64'(ov1), 64'(0));
        chk("abort.in_ready3", 64'(rdy3), 64'(1));
        chk("abort.out_valid3", 64'(ov3), 64'(0));
        issue(32'h40C00000, 32'h40000000, RM_RNE, 1, 0, 0, 8'h80, 24'hC00000, 3'b000, 3'b000, 5'b00000);
        drain();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
